rob_ring: RTL and testbench

Parametrised circular reorder buffer between rename/dispatch and the architectural register file. Allocates entries in program order and accepts out-of-order completions by ROB tag. Broadcasts completion wakeups to the issue queue and retires up to RETIRE_W completed entries per cycle in order. Retired old destinations return to the free list; store data is released to memory.

---
 rtl/rob_pkg.sv | 21 ++
 rtl/rob_retire_sel.sv | 33 +++
 rtl/rob_ring.sv | 205 ++++++++++++++++++++
 tb/tb_rob_ring.sv | 341 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rob_pkg.sv
// rob_pkg: shared entry layout and defaults for the reorder buffer.
package rob_pkg;

  localparam int PREG_W_DEF = 6;
  localparam int XLEN_DEF   = 32;

  localparam logic [6:0] OPC_STORE = 7'b0100011;

  typedef struct packed {
    logic                  valid;
    logic                  done;
    logic                  is_store;
    logic [PREG_W_DEF-1:0] dr;
    logic [PREG_W_DEF-1:0] old_dr;
    logic [XLEN_DEF-1:0]   data;
    logic [XLEN_DEF-1:0]   store_addr;
    logic [XLEN_DEF-1:0]   store_data;
    logic [XLEN_DEF-1:0]   pc;
  } rob_entry_t;

endpackage

// File: rtl/rob_retire_sel.sv
// rob_retire_sel: in-order retire lane selection from the head window.
module rob_retire_sel #(
  parameter int RETIRE_W = 2
) (
  input  logic [RETIRE_W-1:0] valid_i,
  input  logic [RETIRE_W-1:0] done_i,
  input  logic [RETIRE_W-1:0] store_i,
  output logic [RETIRE_W-1:0] ret_o,
  output logic [2:0]          cnt_o
);

  logic go;
  logic seen_st;

  // a second store in the window closes the group
  always_comb begin
    ret_o   = '0;
    cnt_o   = '0;
    go      = 1'b1;
    seen_st = 1'b0;
    for (int i = 0; i < RETIRE_W; i++) begin
      if (go && valid_i[i] && done_i[i] &&
          !(seen_st && store_i[i])) begin
        ret_o[i] = 1'b1;
        cnt_o    = cnt_o + 3'd1;
        seen_st  = seen_st | store_i[i];
      end else begin
        go = 1'b0;
      end
    end
  end

endmodule

// File: rtl/rob_ring.sv
// rob_ring: circular reorder buffer, in-order alloc/retire, OoO completion.
// Optional flush input enabled by defining ROB_FLUSH_EN.
module rob_ring
  import rob_pkg::*;
#(
  parameter int DEPTH      = 64,
  parameter int PREG_W     = PREG_W_DEF,
  parameter int XLEN       = XLEN_DEF,
  parameter int CMPL_PORTS = 3,
  parameter int RETIRE_W   = 2,
  localparam int TAG_W     = $clog2(DEPTH)
) (
  input  logic                         clk,
  input  logic                         rstn,
`ifdef ROB_FLUSH_EN
  input  logic                         flush,
`endif
  input  logic                         alloc_valid,
  output logic                         alloc_ready,
  input  logic [PREG_W-1:0]            alloc_dr,
  input  logic [PREG_W-1:0]            alloc_old_dr,
  input  logic                         alloc_is_store,
  input  logic [XLEN-1:0]              alloc_store_addr,
  input  logic [XLEN-1:0]              alloc_store_data,
  input  logic [XLEN-1:0]              alloc_pc,
  output logic [TAG_W-1:0]             alloc_tag,
  input  logic [CMPL_PORTS-1:0]        cmpl_valid,
  input  logic [CMPL_PORTS*TAG_W-1:0]  cmpl_tag,
  input  logic [CMPL_PORTS*XLEN-1:0]   cmpl_data,
  output logic [CMPL_PORTS-1:0]        wake_valid,
  output logic [CMPL_PORTS*PREG_W-1:0] wake_preg,
  output logic [CMPL_PORTS*XLEN-1:0]   wake_data,
  output logic [RETIRE_W-1:0]          ret_valid,
  output logic [RETIRE_W-1:0]          ret_is_store,
  output logic [RETIRE_W*PREG_W-1:0]   ret_dr,
  output logic [RETIRE_W*PREG_W-1:0]   ret_old_dr,
  output logic [RETIRE_W*XLEN-1:0]     ret_data,
  output logic [RETIRE_W*XLEN-1:0]     ret_store_addr,
  output logic [RETIRE_W*XLEN-1:0]     ret_pc,
  output logic [TAG_W:0]               count,
  output logic                         empty,
  output logic                         full
);

  logic [DEPTH-1:0]  vld_q, done_q, st_q;
  logic [PREG_W-1:0] dr_q    [DEPTH];
  logic [PREG_W-1:0] odr_q   [DEPTH];
  logic [XLEN-1:0]   data_q  [DEPTH];
  logic [XLEN-1:0]   saddr_q [DEPTH];
  logic [XLEN-1:0]   sdata_q [DEPTH];
  logic [XLEN-1:0]   pc_q    [DEPTH];

  logic [TAG_W-1:0] head_q, head_d;
  logic [TAG_W-1:0] tail_q, tail_d;
  logic [TAG_W:0]   count_q, count_d;

  logic [CMPL_PORTS-1:0]        wv_q;
  logic [CMPL_PORTS*PREG_W-1:0] wp_q;
  logic [CMPL_PORTS*XLEN-1:0]   wd_q;

  logic clr;
`ifdef ROB_FLUSH_EN
  assign clr = !rstn || flush;
`else
  assign clr = !rstn;
`endif

  assign count       = count_q;
  assign empty       = (count_q == '0);
  assign full        = (count_q == (TAG_W+1)'(DEPTH));
  assign alloc_ready = !full;
  assign alloc_tag   = tail_q;
  assign wake_valid  = wv_q;
  assign wake_preg   = wp_q;
  assign wake_data   = wd_q;

  logic alloc_fire;
  assign alloc_fire = alloc_valid && alloc_ready;

  logic [TAG_W-1:0]    ridx [RETIRE_W];
  logic [RETIRE_W-1:0] win_v, win_d, win_s;
  logic [RETIRE_W-1:0] ret_sel;
  logic [2:0]          n_ret;

  always_comb begin
    for (int i = 0; i < RETIRE_W; i++) begin
      ridx[i]  = head_q + TAG_W'(i);
      win_v[i] = vld_q[ridx[i]];
      win_d[i] = done_q[ridx[i]];
      win_s[i] = st_q[ridx[i]];
    end
  end

  rob_retire_sel #(.RETIRE_W(RETIRE_W)) u_sel (
    .valid_i (win_v),
    .done_i  (win_d),
    .store_i (win_s),
    .ret_o   (ret_sel),
    .cnt_o   (n_ret)
  );

  assign ret_valid = ret_sel;

  always_comb begin
    ret_is_store   = '0;
    ret_dr         = '0;
    ret_old_dr     = '0;
    ret_data       = '0;
    ret_store_addr = '0;
    ret_pc         = '0;
    for (int i = 0; i < RETIRE_W; i++) begin
      if (ret_sel[i]) begin
        ret_is_store[i]             = st_q[ridx[i]];
        ret_pc[i*XLEN +: XLEN]      = pc_q[ridx[i]];
        if (st_q[ridx[i]]) begin
          ret_data[i*XLEN +: XLEN]       = sdata_q[ridx[i]];
          ret_store_addr[i*XLEN +: XLEN] = saddr_q[ridx[i]];
        end else begin
          ret_data[i*XLEN +: XLEN]       = data_q[ridx[i]];
          ret_dr[i*PREG_W +: PREG_W]     = dr_q[ridx[i]];
          ret_old_dr[i*PREG_W +: PREG_W] = odr_q[ridx[i]];
        end
      end
    end
  end

  logic [TAG_W-1:0]      ctag [CMPL_PORTS];
  logic [CMPL_PORTS-1:0] acc;

  // duplicate tags: the lowest port keeps the completion
  always_comb begin
    for (int p = 0; p < CMPL_PORTS; p++) begin
      ctag[p] = cmpl_tag[p*TAG_W +: TAG_W];
      acc[p]  = cmpl_valid[p] && vld_q[ctag[p]] &&
                !done_q[ctag[p]];
      for (int q = 0; q < p; q++) begin
        if (cmpl_valid[q] &&
            cmpl_tag[q*TAG_W +: TAG_W] == ctag[p])
          acc[p] = 1'b0;
      end
    end
  end

  always_comb begin
    head_d  = head_q + TAG_W'(n_ret);
    tail_d  = tail_q + TAG_W'(alloc_fire);
    count_d = count_q + (TAG_W+1)'(alloc_fire)
                      - (TAG_W+1)'(n_ret);
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      vld_q   <= '0;
      done_q  <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      wv_q    <= '0;
      wp_q    <= '0;
      wd_q    <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      for (int i = 0; i < RETIRE_W; i++) begin
        if (ret_sel[i]) begin
          vld_q[ridx[i]]  <= 1'b0;
          done_q[ridx[i]] <= 1'b0;
        end
      end
      if (alloc_fire) begin
        vld_q[tail_q]   <= 1'b1;
        done_q[tail_q]  <= 1'b0;
        st_q[tail_q]    <= alloc_is_store;
        dr_q[tail_q]    <= alloc_dr;
        odr_q[tail_q]   <= alloc_old_dr;
        saddr_q[tail_q] <= alloc_store_addr;
        sdata_q[tail_q] <= alloc_store_data;
        pc_q[tail_q]    <= alloc_pc;
      end
      for (int p = 0; p < CMPL_PORTS; p++) begin
        if (acc[p]) begin
          done_q[ctag[p]] <= 1'b1;
          data_q[ctag[p]] <= cmpl_data[p*XLEN +: XLEN];
        end
        wv_q[p] <= acc[p] && !st_q[ctag[p]];
        if (acc[p] && !st_q[ctag[p]]) begin
          wp_q[p*PREG_W +: PREG_W] <= dr_q[ctag[p]];
          wd_q[p*XLEN +: XLEN]     <= cmpl_data[p*XLEN +: XLEN];
        end else begin
          wp_q[p*PREG_W +: PREG_W] <= '0;
          wd_q[p*XLEN +: XLEN]     <= '0;
        end
      end
    end
  end

  for (genvar p = 0; p < CMPL_PORTS; p++) begin : g_chk
    a_alloc_cmpl : assert property (
      @(posedge clk) disable iff (!rstn)
      !(alloc_fire && cmpl_valid[p] &&
        cmpl_tag[p*TAG_W +: TAG_W] == tail_q));
  end

endmodule

// File: tb/tb_rob_ring.sv
// tb_rob_ring: directed checks of alloc, completion, wakeup and retire.
module tb_rob_ring;

  logic        clk;
  logic        rstn;
`ifdef ROB_FLUSH_EN
  logic        flush;
`endif
  logic        alloc_valid;
  logic        alloc_ready;
  logic [5:0]  alloc_dr, alloc_old_dr;
  logic        alloc_is_store;
  logic [31:0] alloc_store_addr, alloc_store_data, alloc_pc;
  logic [5:0]  alloc_tag;
  logic [2:0]  cmpl_valid;
  logic [17:0] cmpl_tag;
  logic [95:0] cmpl_data;
  logic [2:0]  wake_valid;
  logic [17:0] wake_preg;
  logic [95:0] wake_data;
  logic [1:0]  ret_valid, ret_is_store;
  logic [11:0] ret_dr, ret_old_dr;
  logic [63:0] ret_data, ret_store_addr, ret_pc;
  logic [6:0]  count;
  logic        empty, full;

  int n_chk = 0;
  int n_err = 0;

  rob_ring dut (
    .clk              (clk),
    .rstn             (rstn),
`ifdef ROB_FLUSH_EN
    .flush            (flush),
`endif
    .alloc_valid      (alloc_valid),
    .alloc_ready      (alloc_ready),
    .alloc_dr         (alloc_dr),
    .alloc_old_dr     (alloc_old_dr),
    .alloc_is_store   (alloc_is_store),
    .alloc_store_addr (alloc_store_addr),
    .alloc_store_data (alloc_store_data),
    .alloc_pc         (alloc_pc),
    .alloc_tag        (alloc_tag),
    .cmpl_valid       (cmpl_valid),
    .cmpl_tag         (cmpl_tag),
    .cmpl_data        (cmpl_data),
    .wake_valid       (wake_valid),
    .wake_preg        (wake_preg),
    .wake_data        (wake_data),
    .ret_valid        (ret_valid),
    .ret_is_store     (ret_is_store),
    .ret_dr           (ret_dr),
    .ret_old_dr       (ret_old_dr),
    .ret_data         (ret_data),
    .ret_store_addr   (ret_store_addr),
    .ret_pc           (ret_pc),
    .count            (count),
    .empty            (empty),
    .full             (full)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    alloc_valid      = 1'b0;
    alloc_dr         = '0;
    alloc_old_dr     = '0;
    alloc_is_store   = 1'b0;
    alloc_store_addr = '0;
    alloc_store_data = '0;
    alloc_pc         = '0;
    cmpl_valid       = '0;
    cmpl_tag         = '0;
    cmpl_data        = '0;
`ifdef ROB_FLUSH_EN
    flush            = 1'b0;
`endif
  endtask

  task automatic do_reset();
    idle_in();
    rstn = 1'b0;
    step();
    step();
    rstn = 1'b1;
  endtask

  task automatic set_alloc(input int dr, input logic st,
                           input logic [31:0] sa,
                           input logic [31:0] sd);
    alloc_valid      = 1'b1;
    alloc_dr         = 6'(dr);
    alloc_old_dr     = 6'(dr + 10);
    alloc_is_store   = st;
    alloc_store_addr = sa;
    alloc_store_data = sd;
    alloc_pc         = 32'(32'h400 + dr * 4);
  endtask

  task automatic setc(input int p, input int tag,
                      input logic [31:0] d);
    cmpl_valid[p]          = 1'b1;
    cmpl_tag[p*6 +: 6]     = 6'(tag);
    cmpl_data[p*32 +: 32]  = d;
  endtask

  initial begin
    rstn = 1'b0;
    idle_in();
    do_reset();

    // reset state
    chk("rst_empty", 64'(empty), 64'd1);
    chk("rst_full", 64'(full), 64'd0);
    chk("rst_count", 64'(count), 64'd0);
    chk("rst_ready", 64'(alloc_ready), 64'd1);
    chk("rst_tag", 64'(alloc_tag), 64'd0);
    chk("rst_ret", 64'(ret_valid), 64'd0);
    chk("rst_wake", 64'(wake_valid), 64'd0);
    chk("rst_retdr", 64'(ret_dr), 64'd0);

    // fill to capacity with no completions
    for (int i = 0; i < 64; i++) begin
      set_alloc(i, 1'b0, 0, 0);
      chk("fill_tag", 64'(alloc_tag), 64'(i));
      step();
    end
    chk("fill_full", 64'(full), 64'd1);
    chk("fill_ready", 64'(alloc_ready), 64'd0);
    chk("fill_count", 64'(count), 64'd64);
    step();
    chk("over_count", 64'(count), 64'd64);
    chk("over_tag", 64'(alloc_tag), 64'd0);

    // out-of-order completion, in-order retire
    do_reset();
    for (int i = 0; i < 3; i++) begin
      set_alloc(10 + i, 1'b0, 0, 0);
      step();
    end
    idle_in();
    setc(0, 2, 32'h1002);
    step();
    chk("ooo_wv2", 64'(wake_valid), 64'b001);
    chk("ooo_wp2", 64'(wake_preg[5:0]), 64'd12);
    chk("ooo_ret2", 64'(ret_valid), 64'd0);
    idle_in();
    setc(0, 1, 32'h1001);
    step();
    chk("ooo_ret1", 64'(ret_valid), 64'd0);
    idle_in();
    setc(0, 0, 32'h1000);
    step();
    idle_in();
    chk("ooo_ret0", 64'(ret_valid), 64'b11);
    chk("ooo_dr0", 64'(ret_dr), {52'd0, 6'd11, 6'd10});
    chk("ooo_odr0", 64'(ret_old_dr), {52'd0, 6'd21, 6'd20});
    chk("ooo_data0", ret_data, {32'h1001, 32'h1000});
    chk("ooo_pc0", ret_pc, {32'h42c, 32'h428});
    step();
    chk("ooo_retb", 64'(ret_valid), 64'b01);
    chk("ooo_drb", 64'(ret_dr), 64'd12);
    chk("ooo_datab", ret_data, 64'h1002);
    chk("ooo_cnt", 64'(count), 64'd1);
    step();
    chk("ooo_empty", 64'(empty), 64'd1);

    // same tag on two ports, lowest port wins
    do_reset();
    for (int i = 0; i < 6; i++) begin
      set_alloc(10 + i, 1'b0, 0, 0);
      step();
    end
    idle_in();
    setc(0, 5, 32'hAAAA);
    setc(2, 5, 32'hBBBB);
    step();
    chk("dup_wv", 64'(wake_valid), 64'b001);
    chk("dup_wp", 64'(wake_preg), 64'd15);
    chk("dup_wd", 64'(wake_data), 64'hAAAA);
    idle_in();
    setc(0, 0, 32'h10);
    setc(1, 1, 32'h11);
    setc(2, 2, 32'h12);
    step();
    chk("tri_wv", 64'(wake_valid), 64'b111);
    chk("tri_wp", 64'(wake_preg), {46'd0, 6'd12, 6'd11, 6'd10});
    chk("tri_wd", 64'(wake_data[95:64]), 64'h12);
    chk("tri_ret", 64'(ret_valid), 64'b11);
    idle_in();
    setc(0, 3, 32'h13);
    setc(1, 4, 32'h14);
    setc(2, 5, 32'hCCCC);
    step();
    idle_in();
    chk("redo_wv", 64'(wake_valid), 64'b011);
    chk("redo_ret", 64'(ret_valid), 64'b11);
    chk("redo_data", ret_data, {32'h13, 32'h12});
    step();
    chk("dup_ret", 64'(ret_valid), 64'b11);
    chk("dup_data", ret_data, {32'hAAAA, 32'h14});
    chk("dup_wv0", 64'(wake_valid), 64'd0);
    step();
    chk("dup_empty", 64'(empty), 64'd1);

    // two adjacent stores: one store per retire group
    set_alloc(0, 1'b1, 32'h100, 32'hD0);
    step();
    set_alloc(0, 1'b1, 32'h104, 32'hD1);
    step();
    set_alloc(18, 1'b0, 0, 0);
    step();
    idle_in();
    setc(0, 6, 32'h66);
    setc(1, 7, 32'h77);
    setc(2, 8, 32'h88);
    step();
    idle_in();
    chk("st_wv", 64'(wake_valid), 64'b100);
    chk("st_wp", 64'(wake_preg[17:12]), 64'd18);
    chk("st_ret", 64'(ret_valid), 64'b01);
    chk("st_isst", 64'(ret_is_store), 64'b01);
    chk("st_addr", ret_store_addr, 64'h100);
    chk("st_data", ret_data, 64'hD0);
    chk("st_dr", 64'(ret_dr), 64'd0);
    step();
    chk("st2_ret", 64'(ret_valid), 64'b11);
    chk("st2_isst", 64'(ret_is_store), 64'b01);
    chk("st2_data", ret_data, {32'h88, 32'hD1});
    chk("st2_addr", ret_store_addr, 64'h104);
    step();
    chk("st_empty", 64'(empty), 64'd1);

    // fill to 60, drain, then wrap the pointers
    do_reset();
    for (int i = 0; i < 60; i++) begin
      set_alloc(i, 1'b0, 0, 0);
      step();
    end
    idle_in();
    chk("w60_cnt", 64'(count), 64'd60);
    for (int c = 0; c < 20; c++) begin
      idle_in();
      setc(0, 3 * c, 32'(c));
      setc(1, 3 * c + 1, 32'(c));
      setc(2, 3 * c + 2, 32'(c));
      step();
    end
    idle_in();
    for (int n = 0; n < 200 && !empty; n++) step();
    chk("w_drain", 64'(empty), 64'd1);
    chk("w_tag60", 64'(alloc_tag), 64'd60);
    for (int k = 0; k < 8; k++) begin
      set_alloc((60 + k) % 64, 1'b0, 0, 0);
      chk("w_tag", 64'(alloc_tag), 64'((60 + k) % 64));
      step();
    end
    idle_in();
    chk("w_cnt8", 64'(count), 64'd8);
    setc(0, 61, 1);
    setc(1, 62, 2);
    setc(2, 63, 3);
    step();
    chk("w_hold", 64'(ret_valid), 64'd0);
    idle_in();
    setc(0, 0, 4);
    setc(1, 1, 5);
    setc(2, 2, 6);
    step();
    idle_in();
    setc(0, 3, 7);
    step();
    idle_in();
    setc(0, 60, 8);
    step();
    idle_in();
    chk("w_r0", 64'(ret_dr), {52'd0, 6'd61, 6'd60});
    chk("w_c0", 64'(count), 64'd8);
    step();
    chk("w_r1", 64'(ret_dr), {52'd0, 6'd63, 6'd62});
    chk("w_c1", 64'(count), 64'd6);
    step();
    chk("w_r2", 64'(ret_dr), {52'd0, 6'd1, 6'd0});
    chk("w_v2", 64'(ret_valid), 64'b11);
    chk("w_c2", 64'(count), 64'd4);
    step();
    chk("w_r3", 64'(ret_dr), {52'd0, 6'd3, 6'd2});
    chk("w_c3", 64'(count), 64'd2);
    step();
    chk("w_c4", 64'(count), 64'd0);
    chk("w_empty", 64'(empty), 64'd1);

`ifdef ROB_FLUSH_EN
    // flush with a same-cycle alloc and completion
    do_reset();
    for (int i = 0; i < 10; i++) begin
      set_alloc(i, 1'b0, 0, 0);
      step();
    end
    idle_in();
    chk("fl_cnt10", 64'(count), 64'd10);
    set_alloc(30, 1'b0, 0, 0);
    setc(0, 0, 32'h55);
    flush = 1'b1;
    step();
    idle_in();
    chk("fl_empty", 64'(empty), 64'd1);
    chk("fl_count", 64'(count), 64'd0);
    chk("fl_ret", 64'(ret_valid), 64'd0);
    chk("fl_wake", 64'(wake_valid), 64'd0);
    chk("fl_tag", 64'(alloc_tag), 64'd0);
    set_alloc(40, 1'b0, 0, 0);
    step();
    idle_in();
    chk("fl_cnt1", 64'(count), 64'd1);
    chk("fl_tag1", 64'(alloc_tag), 64'd1);
`endif

    $display("Simulation finished: %0d checks, %0d errors",
             n_chk, n_err);
    $finish;
  end

endmodule
